// File: rtl/deq_block_sched.sv
// deq_block_sched: block-level scheduler for the parallel dequantizer array.
// Captures a block header of packed 5-bit word widths and builds the 9-bit
// exclusive prefix-sum (accumulated shift) array one word per cycle. It then
// captures one L2 line and holds every dequantizer input stable until the
// downstream consumer takes the result. Only one block is in flight at a time.
//
// Handshake rule used on all three ports: a transfer happens on the rising
// clock edge where valid and ready are both high. A producer holds valid
// (and its data) until that edge. Every ready/valid driven by this block is
// decoded from the FSM state only, so it never depends combinationally on
// an input.
module deq_block_sched #(
  parameter int L2WIDTH  = 512,
  parameter int WORDSBLK = 16,
  parameter int CNTWIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hdr_valid,
  output logic                  hdr_ready,
  input  logic [5*WORDSBLK-1:0] hdr_bitwidth,
  input  logic                  line_valid,
  output logic                  line_ready,
  input  logic [L2WIDTH-1:0]    line_data,
  output logic [L2WIDTH-1:0]    deq_instr,
  output logic [5*WORDSBLK-1:0] deq_bitwidth,
  output logic [9*WORDSBLK-1:0] deq_accshift,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic                  busy,
  output logic [CNTWIDTH-1:0]   blk_count,
  output logic [2:0]            state_dbg
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ACCUM     = 3'd1,
    WAIT_LINE = 3'd2,
    SETTLE    = 3'd3,
    RESULT    = 3'd4
  } state_t;

  localparam int IDXW = (WORDSBLK > 1) ? $clog2(WORDSBLK) : 1;
  localparam logic [IDXW-1:0]     IDX_LAST = IDXW'(WORDSBLK - 1);
  localparam logic [IDXW-1:0]     IDX_ONE  = IDXW'(1);
  localparam logic [CNTWIDTH-1:0] CNT_ONE  = CNTWIDTH'(1);

  state_t          state;
  state_t          state_nxt;
  logic [9:0]      sum;      // running sum; 16 words * 31 = 496 fits in 10 bits
  logic [IDXW-1:0] idx;      // word currently being accumulated
  logic [4:0]      cur_bw;   // width of word idx, read from the captured header

  assign cur_bw    = deq_bitwidth[5*idx +: 5];
  assign state_dbg = state;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and state-decoded handshake/status outputs.
  always_comb begin
    state_nxt  = state;
    hdr_ready  = 1'b0;
    line_ready = 1'b0;
    res_valid  = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        hdr_ready = 1'b1;
        if (hdr_valid) state_nxt = ACCUM;
      end
      ACCUM: begin
        if (idx == IDX_LAST) state_nxt = WAIT_LINE;
      end
      WAIT_LINE: begin
        line_ready = 1'b1;
        if (line_valid) state_nxt = SETTLE;
      end
      SETTLE: begin
        // Dequantizer output register samples the now-stable inputs.
        state_nxt = RESULT;
      end
      RESULT: begin
        res_valid = 1'b1;
        if (res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: header capture, serial prefix sum, line capture, block counter.
  // The deq_* registers only change in their own capture states, so they stay
  // frozen through SETTLE/RESULT and keep their last values while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deq_instr    <= '0;
      deq_bitwidth <= '0;
      deq_accshift <= '0;
      sum          <= '0;
      idx          <= '0;
      blk_count    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hdr_valid) begin
            deq_bitwidth <= hdr_bitwidth;
            sum          <= '0;
            idx          <= '0;
          end
        end
        ACCUM: begin
          // Exclusive prefix sum: field i gets the sum of words 0..i-1.
          deq_accshift[9*idx +: 9] <= sum[8:0];
          sum                      <= sum + {5'd0, cur_bw};
          idx                      <= idx + IDX_ONE;
        end
        WAIT_LINE: begin
          if (line_valid) deq_instr <= line_data;
        end
        RESULT: begin
          if (res_ready) blk_count <= blk_count + CNT_ONE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_deq_block_sched.sv
// tb_deq_block_sched: directed self-checking bench for deq_block_sched.
// Inputs change right after a falling edge; outputs are sampled on falling
// edges, half a cycle away from the active rising edge.
module tb_deq_block_sched;

  localparam int L2W = 512;
  localparam int NW  = 16;
  localparam int CW  = 16;
  localparam int TMO = 100;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              hdr_valid = 1'b0;
  logic [5*NW-1:0]   hdr_bitwidth = '0;
  logic              line_valid = 1'b0;
  logic [L2W-1:0]    line_data = '0;
  logic              res_ready = 1'b0;

  logic              hdr_ready, line_ready, res_valid, busy;
  logic [L2W-1:0]    deq_instr;
  logic [5*NW-1:0]   deq_bitwidth;
  logic [9*NW-1:0]   deq_accshift;
  logic [CW-1:0]     blk_count;
  logic [2:0]        state_dbg;

  // Narrow-counter instance sharing all inputs, used to observe the wrap.
  logic              hdr_ready_s, line_ready_s, res_valid_s, busy_s;
  logic [L2W-1:0]    deq_instr_s;
  logic [5*NW-1:0]   deq_bitwidth_s;
  logic [9*NW-1:0]   deq_accshift_s;
  logic [1:0]        blk_count_s;
  logic [2:0]        state_dbg_s;

  deq_block_sched #(.L2WIDTH(L2W), .WORDSBLK(NW), .CNTWIDTH(CW)) u_dut (
    .clk(clk), .rst(rst),
    .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .hdr_bitwidth(hdr_bitwidth),
    .line_valid(line_valid), .line_ready(line_ready), .line_data(line_data),
    .deq_instr(deq_instr), .deq_bitwidth(deq_bitwidth), .deq_accshift(deq_accshift),
    .res_valid(res_valid), .res_ready(res_ready), .busy(busy),
    .blk_count(blk_count), .state_dbg(state_dbg)
  );

  deq_block_sched #(.L2WIDTH(L2W), .WORDSBLK(NW), .CNTWIDTH(2)) u_dut_small (
    .clk(clk), .rst(rst),
    .hdr_valid(hdr_valid), .hdr_ready(hdr_ready_s), .hdr_bitwidth(hdr_bitwidth),
    .line_valid(line_valid), .line_ready(line_ready_s), .line_data(line_data),
    .deq_instr(deq_instr_s), .deq_bitwidth(deq_bitwidth_s), .deq_accshift(deq_accshift_s),
    .res_valid(res_valid_s), .res_ready(res_ready), .busy(busy_s),
    .blk_count(blk_count_s), .state_dbg(state_dbg_s)
  );

  int checks = 0;
  int errors = 0;
  logic [CW-1:0]  exp_blk = '0;
  logic [L2W-1:0] last_line = '0;

  // Watchdog: the run is a few hundred cycles; this only fires on a hang.
  initial begin
    #1000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  // ---------------- model / helpers ----------------
  function automatic logic [9*NW-1:0] model_acc(input logic [5*NW-1:0] bw);
    logic [9:0] s;
    s = '0;
    model_acc = '0;
    for (int i = 0; i < NW; i++) begin
      model_acc[9*i +: 9] = s[8:0];
      s = s + {5'd0, bw[5*i +: 5]};
    end
  endfunction

  function automatic logic [L2W-1:0] make_line();
    for (int i = 0; i < L2W/32; i++) make_line[32*i +: 32] = $urandom();
  endfunction

  task automatic wait_hdr_ready(output int n);
    n = 0;
    while (hdr_ready !== 1'b1 && n < TMO) begin @(negedge clk); n++; end
  endtask

  task automatic wait_line_ready(output int n);
    n = 0;
    while (line_ready !== 1'b1 && n < TMO) begin @(negedge clk); n++; end
  endtask

  task automatic wait_res_valid(output int n);
    n = 0;
    while (res_valid !== 1'b1 && n < TMO) begin @(negedge clk); n++; end
  endtask

  task automatic send_header(input logic [5*NW-1:0] bw);
    int n;
    wait_hdr_ready(n);
    hdr_bitwidth = bw;
    hdr_valid = 1'b1;
    @(negedge clk);
    hdr_valid = 1'b0;
  endtask

  task automatic finish_block(input logic [L2W-1:0] data);
    int n;
    wait_line_ready(n);
    line_data = data;
    line_valid = 1'b1;
    @(negedge clk);
    line_valid = 1'b0;
    last_line = data;
    wait_res_valid(n);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    exp_blk++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    checks++; if (res_valid !== 1'b0 || busy !== 1'b0 || line_ready !== 1'b0) begin
      errors++; $display("FAIL reset_status got rv=%b busy=%b lr=%b exp 0 0 0", res_valid, busy, line_ready); end
    rst = 1'b0;
    exp_blk = '0;
    last_line = '0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++; if (hdr_ready !== 1'b1) begin errors++; $display("FAIL idle_hdr_ready cyc %0d got %b exp 1", c, hdr_ready); end
      checks++; if (line_ready !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL idle_flags cyc %0d got lr=%b rv=%b busy=%b exp 0 0 0", c, line_ready, res_valid, busy); end
      checks++; if (deq_instr !== '0 || deq_bitwidth !== '0 || deq_accshift !== '0) begin
        errors++; $display("FAIL idle_deq_zero cyc %0d got bw=%h acc=%h exp 0", c, deq_bitwidth, deq_accshift); end
      checks++; if (blk_count !== 16'd0 || blk_count_s !== 2'd0) begin
        errors++; $display("FAIL idle_blk_count cyc %0d got %0d/%0d exp 0", c, blk_count, blk_count_s); end
    end
  endtask

  // One full block with latency, prefix-sum and counter checks.
  task automatic test_block(input string name, input logic [5*NW-1:0] bw, input logic [8:0] exp_f15);
    int n;
    logic [L2W-1:0] data;
    send_header(bw);
    checks++; if (deq_bitwidth !== bw) begin errors++; $display("FAIL %s_bitwidth got %h exp %h", name, deq_bitwidth, bw); end
    checks++; if (busy !== 1'b1 || hdr_ready !== 1'b0) begin errors++; $display("FAIL %s_accum_flags got busy=%b hr=%b exp 1 0", name, busy, hdr_ready); end
    wait_line_ready(n);
    checks++; if (n != 16) begin errors++; $display("FAIL %s_hdr_to_line got %0d exp 16", name, n); end
    data = make_line();
    line_data = data;
    line_valid = 1'b1;
    @(negedge clk);
    line_valid = 1'b0;
    last_line = data;
    checks++; if (deq_instr !== data) begin errors++; $display("FAIL %s_instr got %h exp %h", name, deq_instr[63:0], data[63:0]); end
    wait_res_valid(n);
    checks++; if (n != 1) begin errors++; $display("FAIL %s_line_to_res got %0d exp 1", name, n); end
    checks++; if (deq_accshift !== model_acc(bw)) begin errors++; $display("FAIL %s_accshift got %h exp %h", name, deq_accshift, model_acc(bw)); end
    checks++; if (deq_accshift[9*15 +: 9] !== exp_f15 || deq_accshift[8:0] !== 9'd0) begin
      errors++; $display("FAIL %s_field15 got %0d f0=%0d exp %0d f0=0", name, deq_accshift[9*15 +: 9], deq_accshift[8:0], exp_f15); end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    exp_blk++;
    checks++; if (res_valid !== 1'b0 || hdr_ready !== 1'b1) begin errors++; $display("FAIL %s_after_res got rv=%b hr=%b exp 0 1", name, res_valid, hdr_ready); end
    checks++; if (blk_count !== exp_blk) begin errors++; $display("FAIL %s_blk_count got %0d exp %0d", name, blk_count, exp_blk); end
  endtask

  task automatic test_backpressure();
    logic [5*NW-1:0] bw1, bw2;
    logic [9*NW-1:0] acc1;
    logic [L2W-1:0]  data;
    int n;
    bw1 = {NW{5'd5}};
    acc1 = model_acc(bw1);
    for (int i = 0; i < NW; i++) bw2[5*i +: 5] = 5'(i * 3);
    data = make_line();
    send_header(bw1);
    wait_line_ready(n);
    line_data = data; line_valid = 1'b1;
    @(negedge clk);
    line_valid = 1'b0;
    wait_res_valid(n);
    hdr_bitwidth = bw2;
    hdr_valid = 1'b1;
    for (int c = 0; c < 50; c++) begin
      checks++; if (res_valid !== 1'b1 || hdr_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold_flags cyc %0d got rv=%b hr=%b exp 1 0", c, res_valid, hdr_ready); end
      checks++; if (deq_instr !== data || deq_accshift !== acc1 || deq_bitwidth !== bw1) begin
        errors++; $display("FAIL bp_hold_data cyc %0d got acc=%h exp %h", c, deq_accshift, acc1); end
      @(negedge clk);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    exp_blk++;
    checks++; if (hdr_ready !== 1'b1 || blk_count !== exp_blk) begin
      errors++; $display("FAIL bp_release got hr=%b cnt=%0d exp 1 %0d", hdr_ready, blk_count, exp_blk); end
    @(negedge clk);
    hdr_valid = 1'b0;
    checks++; if (busy !== 1'b1 || deq_bitwidth !== bw2) begin
      errors++; $display("FAIL bp_stalled_hdr got busy=%b bw=%h exp 1 %h", busy, deq_bitwidth, bw2); end
    finish_block(make_line());
    checks++; if (deq_accshift !== model_acc(bw2) || blk_count !== exp_blk) begin
      errors++; $display("FAIL bp_second_block got acc=%h cnt=%0d exp %h %0d", deq_accshift, blk_count, model_acc(bw2), exp_blk); end
  endtask

  task automatic test_line_early();
    logic [L2W-1:0] d;
    int n;
    line_valid = 1'b1;
    line_data = make_line();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if (line_ready !== 1'b0 || busy !== 1'b0 || deq_instr !== last_line) begin
        errors++; $display("FAIL early_idle cyc %0d got lr=%b busy=%b exp 0 0", c, line_ready, busy); end
    end
    send_header({NW{5'd2}});
    n = 0;
    while (line_ready !== 1'b1 && n < TMO) begin
      line_data = make_line();
      checks++; if (deq_instr !== last_line) begin errors++; $display("FAIL early_accum_instr cyc %0d got %h exp %h", n, deq_instr[63:0], last_line[63:0]); end
      @(negedge clk);
      n++;
    end
    checks++; if (n != 16) begin errors++; $display("FAIL early_hdr_to_line got %0d exp 16", n); end
    d = make_line();
    line_data = d;
    @(negedge clk);
    line_valid = 1'b0;
    last_line = d;
    checks++; if (deq_instr !== d || line_ready !== 1'b0) begin
      errors++; $display("FAIL early_capture got %h lr=%b exp %h 0", deq_instr[63:0], line_ready, d[63:0]); end
    wait_res_valid(n);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    exp_blk++;
    checks++; if (blk_count !== exp_blk) begin errors++; $display("FAIL early_blk_count got %0d exp %0d", blk_count, exp_blk); end
  endtask

  task automatic test_reset_midblock();
    int n;
    // Reset while accumulating word index 7.
    send_header({NW{5'd9}});
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || hdr_ready !== 1'b1 || res_valid !== 1'b0 || line_ready !== 1'b0) begin
      errors++; $display("FAIL rst_accum_flags got busy=%b hr=%b rv=%b lr=%b exp 0 1 0 0", busy, hdr_ready, res_valid, line_ready); end
    checks++; if (deq_accshift !== '0 || deq_bitwidth !== '0 || deq_instr !== '0 || blk_count !== 16'd0) begin
      errors++; $display("FAIL rst_accum_regs got acc=%h cnt=%0d exp 0 0", deq_accshift, blk_count); end
    @(negedge clk);
    rst = 1'b0;
    exp_blk = '0;
    last_line = '0;
    line_valid = 1'b1;
    res_ready = 1'b1;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      checks++; if (res_valid !== 1'b0 || line_ready !== 1'b0 || deq_instr !== '0) begin
        errors++; $display("FAIL rst_no_result cyc %0d got rv=%b lr=%b exp 0 0", c, res_valid, line_ready); end
    end
    line_valid = 1'b0;
    res_ready = 1'b0;
    // Reset while holding a result.
    send_header({NW{5'd1}});
    wait_line_ready(n);
    line_data = make_line(); line_valid = 1'b1;
    @(negedge clk);
    line_valid = 1'b0;
    wait_res_valid(n);
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL rst_result_reach got %b exp 1", res_valid); end
    rst = 1'b1;
    #1;
    checks++; if (res_valid !== 1'b0 || busy !== 1'b0 || blk_count !== 16'd0 || blk_count_s !== 2'd0) begin
      errors++; $display("FAIL rst_result got rv=%b busy=%b cnt=%0d exp 0 0 0", res_valid, busy, blk_count); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // All valids/readys held high: 20-cycle block period and counter wrap.
  task automatic test_back_to_back();
    logic [CW-1:0] prev;
    logic [L2W-1:0] d;
    int n;
    d = make_line();
    hdr_bitwidth = {NW{5'd8}};
    line_data = d;
    hdr_valid = 1'b1;
    line_valid = 1'b1;
    res_ready = 1'b1;
    for (int b = 1; b <= 4; b++) begin
      prev = blk_count;
      n = 0;
      while (blk_count === prev && n < 60) begin @(negedge clk); n++; end
      exp_blk++;
      checks++; if (blk_count !== exp_blk || blk_count_s !== exp_blk[1:0]) begin
        errors++; $display("FAIL b2b_count blk %0d got %0d/%0d exp %0d/%0d", b, blk_count, blk_count_s, exp_blk, exp_blk[1:0]); end
      if (b > 1) begin
        checks++; if (n != 20) begin errors++; $display("FAIL b2b_period blk %0d got %0d exp 20", b, n); end
      end
    end
    hdr_valid = 1'b0;
    line_valid = 1'b0;
    res_ready = 1'b0;
    checks++; if (blk_count_s !== 2'd0 || deq_instr !== d) begin
      errors++; $display("FAIL b2b_wrap got %0d exp 0", blk_count_s); end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    logic [5*NW-1:0] bw_alt, bw_mix;
    for (int i = 0; i < NW; i++) begin
      bw_alt[5*i +: 5] = (i % 2 == 1) ? 5'd31 : 5'd0;
      bw_mix[5*i +: 5] = 5'(i + 1);
    end
    test_reset();
    test_block("all8", {NW{5'd8}}, 9'd120);
    test_block("alt", bw_alt, 9'd217);
    test_block("mix", bw_mix, 9'd120);
    test_backpressure();
    test_line_early();
    test_reset_midblock();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
